inta_sequencer: RTL
===================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL provide parameter ACK_TIMEOUT, default 255: the number of clk cycles to wait in ACK1 for the second acknowledge before aborting (legal range 1..255).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL provide port ir, input, 8, level-sensitive interrupt requests IR7..IR0.
REQ-005 SHALL provide port imr, input, 8, interrupt mask; 1 masks the corresponding IR.
REQ-006 SHALL provide port icw2_base, input, 5, vector bits T7-T3 programmed by ICW2.
REQ-007 SHALL provide port inta, input, 1, one-cycle strobe per CPU INTA pulse, already synchronised to clk.
REQ-008 SHALL provide port eoi, input, 1, one-cycle EOI command strobe.
REQ-009 SHALL provide port eoi_specific, input, 1, qualifies eoi: 1 = specific, 0 = non-specific.
REQ-010 SHALL provide port eoi_level, input, 3, the IR level cleared by a specific EOI.
REQ-011 SHALL provide port int_out, output, 1, the registered interrupt request to the CPU.
REQ-012 SHALL provide port irr, output, 8, the registered interrupt request register.
REQ-013 SHALL provide port isr, output, 8, the in-service register.
REQ-014 SHALL provide port vector, output, 8, the interrupt vector driven to the data bus.
REQ-015 SHALL provide port vector_valid, output, 1, a one-cycle qualifier for vector.

Function
REQ-016 irr SHALL load ir every cycle, except the bit acknowledged in that cycle, which SHALL be forced to 0.
REQ-017 Priority SHALL be fixed with IR0 highest. The candidate SHALL be the lowest index i with irr[i]=1, imr[i]=0, and no isr bit set at index <= i (fully nested).
REQ-018 The FSM SHALL have states IDLE, REQ and ACK1, with IDLE entered on reset.
REQ-019 In IDLE, if a candidate exists, the FSM SHALL move to REQ and int_out SHALL be 1 from the next cycle; otherwise it SHALL remain in IDLE.
REQ-020 In REQ without inta, if the candidate disappears, the FSM SHALL return to IDLE and int_out SHALL drop to 0 the next cycle.
REQ-021 In REQ with inta, the FSM SHALL latch level = candidate, set isr[level], clear irr[level], deassert int_out, clear the timeout counter and move to ACK1.
REQ-022 Spurious acknowledge: if inta occurs in REQ with no candidate, level SHALL be 7, isr SHALL be unchanged, and the FSM SHALL move to ACK1.
REQ-023 In ACK1 with inta, vector SHALL be {icw2_base, level} and vector_valid SHALL be 1 for exactly one cycle; the FSM SHALL then go to IDLE. Acknowledge-to-vector latency SHALL be 1 cycle after the second inta.
REQ-024 In ACK1 without inta, the counter SHALL increment. When the counter reaches ACK_TIMEOUT, the FSM SHALL clear isr[level] (if set by this sequence), go to IDLE and issue no vector_valid.
REQ-025 inta in IDLE SHALL be ignored.
REQ-026 vector SHALL hold its last value when vector_valid is 0.
REQ-027 A non-specific EOI SHALL clear the lowest-index set isr bit; if no isr bit is set, it SHALL have no effect.
REQ-028 A specific EOI SHALL clear isr[eoi_level] only.
REQ-029 If an EOI clear and an acknowledge set target the same isr bit in the same cycle, the set SHALL win; if they target different bits, both SHALL apply.
REQ-030 EOI SHALL be accepted in every FSM state.

Reset
REQ-031 On reset=1 at a clk edge, the FSM SHALL be IDLE and the counter, level, int_out, irr, isr, vector and vector_valid SHALL all be 0.
REQ-032 Reset asserted mid-sequence (REQ or ACK1) SHALL abort the sequence with no vector_valid issued.

Configuration
REQ-033 Macro INTA_SEQ_AUTO_EOI_EN SHALL control automatic EOI.
- Defined: the second inta in ACK1 SHALL also clear isr[level] in the same cycle vector_valid asserts; the eoi inputs remain functional.
- Undefined: isr bits SHALL clear only via EOI or timeout.

Verification
REQ-034 Scenario: ir=8'h08, imr=0, icw2_base=5'h09 -> int_out=1; inta -> isr=8'h08, irr[3]=0, int_out=0; second inta -> vector=8'h4B, vector_valid=1 for 1 cycle.
REQ-035 Scenario: isr=8'h04 in service, ir=8'h82 -> IR1 served, vector low bits 3'd1; IR7 blocked until a non-specific EOI clears isr[1] and then isr[2].
REQ-036 Scenario: int_out=1, then ir drops before inta, then inta -> vector low bits 3'd7, isr=0.
REQ-037 Scenario: ACK_TIMEOUT=4, first inta on IR2 with no second inta -> isr[2]=0 after 4 cycles, FSM in IDLE, vector_valid never 1.
REQ-038 Scenario: specific EOI eoi_level=5 in the same cycle as first inta on IR5 -> isr[5]=1.
REQ-039 Scenario: INTA_SEQ_AUTO_EOI_EN defined, full sequence on IR6 -> isr=0 in the cycle after vector_valid.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: fixed-priority, fully nested interrupt acknowledge sequencer.
//
// Ports:
//   clk            clock; all state updates on its rising edge
//   reset          synchronous active-high reset
//   ir[7:0]        level-sensitive interrupt requests IR7..IR0
//   imr[7:0]       interrupt mask, 1 masks the corresponding IR
//   icw2_base[4:0] vector bits T7..T3
//   inta           one-cycle strobe per CPU INTA pulse (already synchronised)
//   eoi            one-cycle EOI command strobe
//   eoi_specific   1 = specific EOI, 0 = non-specific EOI
//   eoi_level[2:0] level cleared by a specific EOI
//   int_out        registered interrupt request to the CPU
//   irr[7:0]       interrupt request register
//   isr[7:0]       in-service register
//   vector[7:0]    interrupt vector, holds its value between acknowledges
//   vector_valid   one-cycle qualifier for vector
//
// Build option: define INTA_SEQ_AUTO_EOI_EN to clear the served in-service
// bit automatically on the second INTA.
module inta_sequencer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic [4:0] icw2_base,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [7:0] vector,
    output logic       vector_valid
);

`ifdef INTA_SEQ_AUTO_EOI_EN
    localparam bit AUTO_EOI = 1'b1;
`else
    localparam bit AUTO_EOI = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, ACK1} state_t;

    state_t     state_q, state_d;
    logic [7:0] irr_q, isr_q, vector_q, vector_d, cnt_q, cnt_d;
    logic [2:0] level_q, level_d;
    logic       owned_q, owned_d, vv_q, vv_d, int_out_q;
    logic       cand_vld, blocked;
    logic [2:0] cand_idx;
    logic [7:0] ack_set, seq_clr, eoi_clr, lvl_mask;

    // Lowest-index unmasked request with no in-service bit at or below it.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = 3'd0;
        blocked  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            blocked = blocked | isr_q[i];
            if (!cand_vld && !blocked && irr_q[i] && !imr[i]) begin
                cand_vld = 1'b1;
                cand_idx = 3'(i);
            end
        end
    end

    assign lvl_mask = 8'd1 << level_q;

    // Non-specific EOI isolates the lowest set in-service bit.
    assign eoi_clr = !eoi ? 8'd0 :
                     eoi_specific ? (8'd1 << eoi_level) : (isr_q & (~isr_q + 8'd1));

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        owned_d  = owned_q;
        vector_d = vector_q;
        vv_d     = 1'b0;
        ack_set  = 8'd0;
        seq_clr  = 8'd0;
        case (state_q)
            IDLE: state_d = cand_vld ? REQ : IDLE;
            REQ: begin
                if (inta) begin
                    // No candidate left at acknowledge time: spurious, level 7.
                    state_d = ACK1;
                    level_d = cand_vld ? cand_idx : 3'd7;
                    owned_d = cand_vld;
                    ack_set = cand_vld ? (8'd1 << cand_idx) : 8'd0;
                    cnt_d   = 8'd0;
                end else if (!cand_vld) begin
                    state_d = IDLE;
                end
            end
            ACK1: begin
                if (inta) begin
                    state_d  = IDLE;
                    vector_d = {icw2_base, level_q};
                    vv_d     = 1'b1;
                    seq_clr  = (AUTO_EOI && owned_q) ? lvl_mask : 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(ACK_TIMEOUT)) begin
                        state_d = IDLE;
                        seq_clr = owned_q ? lvl_mask : 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            irr_q     <= 8'd0;
            isr_q     <= 8'd0;
            vector_q  <= 8'd0;
            cnt_q     <= 8'd0;
            level_q   <= 3'd0;
            owned_q   <= 1'b0;
            vv_q      <= 1'b0;
            int_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            irr_q     <= ir & ~ack_set;
            // An acknowledge set overrides any clear aimed at the same bit.
            isr_q     <= (isr_q & ~eoi_clr & ~seq_clr) | ack_set;
            vector_q  <= vector_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            owned_q   <= owned_d;
            vv_q      <= vv_d;
            int_out_q <= (state_d == REQ);
        end
    end

    assign int_out      = int_out_q;
    assign irr          = irr_q;
    assign isr          = isr_q;
    assign vector       = vector_q;
    assign vector_valid = vv_q;

endmodule
